// File: rtl/dircc_state_store.sv
// dircc_state_store: per-device state slot store with self-clearing start-up.
//
// Ports:
//   clk, reset            - single rising-edge clock, synchronous active-high reset
//   rd_req, rd_address    - read request and slot index
//   read_state, read_valid- read data, valid one cycle after an accepted request
//   write_address, write_state, write_state_valid - write-back port, no backpressure
//   init_done             - store has been cleared and accepts traffic
//   addr_error            - sticky: an access addressed a slot >= DEPTH
//   drop_error            - sticky: an access arrived while the store was clearing
//   write_count           - accepted in-range write counter (saturating)
//
// Optional feature: define DIRCC_STATE_STORE_WRITE_COUNT_EN to build the
// write counter; otherwise write_count is tied to zero.

package dircc_application_pkg;

    typedef struct packed {
        logic [7:0]  mode;
        logic [7:0]  flags;
        logic [15:0] payload;
    } device_state_t;

endpackage

module dircc_state_store
    import dircc_application_pkg::*;
#(
    parameter int unsigned ADDRESS_MEM_WIDTH = 32,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned DEVICE_ID         = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_req,
    input  logic [ADDRESS_MEM_WIDTH-1:0] rd_address,
    output device_state_t                read_state,
    output logic                         read_valid,
    input  logic [ADDRESS_MEM_WIDTH-1:0] write_address,
    input  device_state_t                write_state,
    input  logic                         write_state_valid,
    output logic                         init_done,
    output logic                         addr_error,
    output logic                         drop_error,
    output logic [15:0]                  write_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDRESS_MEM_WIDTH:0] DEPTH_EXT = (ADDRESS_MEM_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clear_idx_q, clear_idx_d;

    device_state_t    mem [DEPTH];

    logic             rd_in_range_c, wr_in_range_c;
    logic [IDX_W-1:0] rd_idx_c, wr_idx_c;
    logic             rd_accept_c, wr_accept_c;
    logic             drop_c, addr_err_c;
    device_state_t    rd_data_c;

    // Range checks widen by one bit so DEPTH never overflows the address width.
    assign rd_in_range_c = {1'b0, rd_address} < DEPTH_EXT;
    assign wr_in_range_c = {1'b0, write_address} < DEPTH_EXT;
    assign rd_idx_c      = rd_address[IDX_W-1:0];
    assign wr_idx_c      = write_address[IDX_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clear_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    // Next-state and access qualification.
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        rd_accept_c = 1'b0;
        wr_accept_c = 1'b0;
        drop_c      = 1'b0;
        addr_err_c  = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_idx_d = clear_idx_q + 1'b1;
                if (clear_idx_q == LAST_IDX) begin
                    state_d = READY;
                end
                drop_c = rd_req | write_state_valid;
            end
            READY: begin
                rd_accept_c = rd_req;
                wr_accept_c = write_state_valid & wr_in_range_c;
                addr_err_c  = (rd_req & ~rd_in_range_c)
                            | (write_state_valid & ~wr_in_range_c);
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Read mux: out-of-range reads return zero, same-slot writes bypass the array.
    always_comb begin
        rd_data_c = '0;
        if (rd_in_range_c) begin
            if (wr_accept_c && (wr_idx_c == rd_idx_c)) begin
                rd_data_c = write_state;
            end else begin
                rd_data_c = mem[rd_idx_c];
            end
        end
    end

    // Storage array: zero-fill while clearing, write-back once ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[clear_idx_q] <= '0;
            end else if (wr_accept_c) begin
                mem[wr_idx_c] <= write_state;
            end
        end
    end

    // Registered outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_state <= '0;
            read_valid <= 1'b0;
            init_done  <= 1'b0;
            addr_error <= 1'b0;
            drop_error <= 1'b0;
        end else begin
            read_valid <= rd_accept_c;
            init_done  <= (state_d == READY);
            if (rd_accept_c) begin
                read_state <= rd_data_c;
            end
            if (addr_err_c) begin
                addr_error <= 1'b1;
            end
            if (drop_c) begin
                drop_error <= 1'b1;
            end
        end
    end

`ifdef DIRCC_STATE_STORE_WRITE_COUNT_EN
    logic [15:0] write_count_q;

    // Saturating count of accepted in-range writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_count_q <= '0;
        end else if (wr_accept_c && (write_count_q != 16'hFFFF)) begin
            write_count_q <= write_count_q + 16'd1;
        end
    end

    assign write_count = write_count_q;
`else
    assign write_count = '0;
`endif

endmodule

// File: tb/tb_dircc_state_store.sv
// Directed bench for dircc_state_store with a read-data scoreboard queue.
module tb_dircc_state_store;
    import dircc_application_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_address;
    device_state_t read_state;
    logic          read_valid;
    logic [AW-1:0] write_address;
    device_state_t write_state;
    logic          write_state_valid;
    logic          init_done;
    logic          addr_error;
    logic          drop_error;
    logic [15:0]   write_count;

    int checks = 0;
    int errors = 0;

    logic [31:0]  model_mem [DEPTH];
    logic [31:0]  exp_q [$];
    bit           model_ready;
    int unsigned  model_wcount;
    logic [31:0]  last_read;

    dircc_state_store #(
        .ADDRESS_MEM_WIDTH(AW),
        .DEPTH(DEPTH),
        .DEVICE_ID(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_req(rd_req),
        .rd_address(rd_address),
        .read_state(read_state),
        .read_valid(read_valid),
        .write_address(write_address),
        .write_state(write_state),
        .write_state_valid(write_state_valid),
        .init_done(init_done),
        .addr_error(addr_error),
        .drop_error(drop_error),
        .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of traffic; the model predicts read data and queues it.
    task automatic tick(input bit rd, input int unsigned ra, input bit wr,
                        input int unsigned wa, input logic [31:0] wd);
        bit          pend;
        logic [31:0] e;
        rd_req            = rd;
        rd_address        = AW'(ra);
        write_state_valid = wr;
        write_address     = AW'(wa);
        write_state       = device_state_t'(wd);
        pend = 1'b0;
        if (model_ready) begin
            if (rd) begin
                if (ra >= DEPTH)              e = 32'h0;
                else if (wr && (wa == ra))    e = wd;
                else                          e = model_mem[ra];
                exp_q.push_back(e);
                pend = 1'b1;
            end
            if (wr && (wa < DEPTH)) begin
                model_mem[wa] = wd;
                if (model_wcount < 32'hFFFF) model_wcount++;
            end
        end
        @(posedge clk);
        #1;
        rd_req            = 1'b0;
        write_state_valid = 1'b0;
        check("read_valid", {31'b0, read_valid}, {31'b0, pend});
        if (pend) begin
            e = exp_q.pop_front();
            check($sformatf("read_state[%0d]", ra), read_state, e);
            last_read = e;
        end else begin
            check("read_hold", read_state, last_read);
        end
    endtask

    // Counts edges from reset release until init_done, bounded.
    task automatic wait_init();
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (init_done) begin
                n = i;
                break;
            end
        end
        check("init_latency", 32'(n), 32'd16);
    endtask

    function automatic logic [31:0] exp_wcount();
`ifdef DIRCC_STATE_STORE_WRITE_COUNT_EN
        return model_wcount;
`else
        return 32'h0;
`endif
    endfunction

    initial begin
        reset             = 1'b1;
        rd_req            = 1'b0;
        rd_address        = '0;
        write_address     = '0;
        write_state       = '0;
        write_state_valid = 1'b0;
        model_ready       = 1'b0;
        model_wcount      = 0;
        last_read         = 32'h0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_read_state", read_state, 32'h0);
        check("rst_read_valid", {31'b0, read_valid}, 32'h0);
        check("rst_init_done",  {31'b0, init_done}, 32'h0);
        check("rst_addr_error", {31'b0, addr_error}, 32'h0);
        check("rst_drop_error", {31'b0, drop_error}, 32'h0);
        check("rst_write_count", {16'h0, write_count}, 32'h0);

        reset = 1'b0;
        wait_init();
        model_ready = 1'b1;

        // Every slot reads zero after the clear.
        for (int i = 0; i < DEPTH; i++) tick(1'b1, i, 1'b0, 0, 32'h0);

        // Write then read back, neighbour untouched.
        tick(1'b0, 0, 1'b1, 3, 32'hA5A5_A5A5);
        tick(1'b1, 3, 1'b0, 0, 32'h0);
        tick(1'b1, 4, 1'b0, 0, 32'h0);

        // Same-cycle write and read of one slot returns the new data.
        tick(1'b1, 7, 1'b1, 7, 32'h1234_5678);
        tick(1'b0, 0, 1'b0, 0, 32'h0);
        check("addr_error_clean", {31'b0, addr_error}, 32'h0);

        // Out-of-range write is discarded, out-of-range read returns zero.
        tick(1'b0, 0, 1'b1, 16, 32'hDEAD_BEEF);
        check("addr_error_wr", {31'b0, addr_error}, 32'h1);
        tick(1'b1, 20, 1'b0, 0, 32'h0);
        for (int i = 0; i < DEPTH; i++) tick(1'b1, i, 1'b0, 0, 32'h0);
        check("drop_error_ready", {31'b0, drop_error}, 32'h0);

        tick(1'b0, 0, 1'b1, 9, 32'h0F0F_F0F0);
        tick(1'b1, 9, 1'b0, 0, 32'h0);
        tick(1'b0, 0, 1'b0, 0, 32'h0);
        check("write_count", {16'h0, write_count}, exp_wcount());
        check("addr_error_sticky", {31'b0, addr_error}, 32'h1);

        // Re-reset, then access during clear and reset again mid-clear.
        model_ready = 1'b0;
        reset       = 1'b1;
        last_read   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_wcount = 0;
        check("rerst_addr_error", {31'b0, addr_error}, 32'h0);
        check("rerst_write_count", {16'h0, write_count}, 32'h0);
        repeat (4) tick(1'b0, 0, 1'b0, 0, 32'h0);
        tick(1'b1, 2, 1'b0, 0, 32'h0);
        check("drop_error_clear", {31'b0, drop_error}, 32'h1);
        check("init_done_clear",  {31'b0, init_done}, 32'h0);
        repeat (2) tick(1'b0, 0, 1'b0, 0, 32'h0);
        reset = 1'b1;
        tick(1'b0, 0, 1'b0, 0, 32'h0);
        reset = 1'b0;
        check("drop_error_rst", {31'b0, drop_error}, 32'h0);
        wait_init();
        model_ready = 1'b1;
        tick(1'b1, 3, 1'b0, 0, 32'h0);
        tick(1'b1, 7, 1'b0, 0, 32'h0);
        check("final_write_count", {16'h0, write_count}, exp_wcount());
        check("final_drop_error", {31'b0, drop_error}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dircc_state_store.md
DIRCC_STATE_STORE -- requirements
Module: dircc_state_store

Interface
REQ-001 SHALL have parameter ADDRESS_MEM_WIDTH, default 32: width of rd_address and write_address.
REQ-002 SHALL have parameter DEPTH, default 16: number of device state slots, power of two, minimum 2.
REQ-003 SHALL have parameter DEVICE_ID, default 0: identifier only, no functional effect.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on rising edge of clk.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port rd_req, input, 1 bit: read request.
REQ-007 SHALL have port rd_address, input, ADDRESS_MEM_WIDTH bits: read slot index.
REQ-008 SHALL have port read_state, output, device_state_t (dircc_application_pkg): read data.
REQ-009 SHALL have port read_valid, output, 1 bit: read_state valid.
REQ-010 SHALL have port write_address, input, ADDRESS_MEM_WIDTH bits: write slot index.
REQ-011 SHALL have port write_state, input, device_state_t: write-back data.
REQ-012 SHALL have port write_state_valid, input, 1 bit: write strobe.
REQ-013 SHALL have port init_done, output, 1 bit: store cleared and ready.
REQ-014 SHALL have port addr_error, output, 1 bit: sticky out-of-range flag.
REQ-015 SHALL have port drop_error, output, 1 bit: sticky flag for access during clear.
REQ-016 SHALL have port write_count, output, 16 bits: accepted-write counter (see Configuration).

Function
REQ-017 SHALL implement a two-state FSM: CLEAR and READY; reset enters CLEAR with clear index 0.
REQ-018 In CLEAR SHALL write all-zero state to slot[index] each cycle, index +1; after writing slot DEPTH-1, SHALL enter READY next cycle; clear takes exactly DEPTH cycles.
REQ-019 init_done SHALL be 0 in CLEAR and 1 in READY.
REQ-020 In CLEAR, rd_req or write_state_valid SHALL be ignored (no read_valid, no memory update) and SHALL set drop_error.
REQ-021 In READY, rd_req in cycle N SHALL give read_valid=1 and read_state in cycle N+1; read_valid SHALL be 0 in any cycle not following an accepted rd_req.
REQ-022 In READY, write_state_valid SHALL update slot[write_address] at the clock edge; one write per cycle, no backpressure.
REQ-023 Same-cycle rd_req and write_state_valid to the same in-range address SHALL return the new write_state (write-first bypass).
REQ-024 Address >= DEPTH SHALL set addr_error; an out-of-range write SHALL be discarded; an out-of-range read SHALL still assert read_valid with read_state = 0.
REQ-025 read_state SHALL hold its last value while read_valid is 0.
REQ-026 Sticky flags SHALL clear only on reset.

Reset
REQ-027 On reset: read_state=0, read_valid=0, init_done=0, addr_error=0, drop_error=0, write_count=0, FSM=CLEAR, index=0.
REQ-028 Reset asserted mid-CLEAR or in READY SHALL restart the full clear from slot 0; in-flight reads SHALL be dropped.

Configuration
REQ-029 Macro DIRCC_STATE_STORE_WRITE_COUNT_EN defined: write_count SHALL increment by 1 per accepted in-range write in READY, saturating at 16'hFFFF.
REQ-030 Macro undefined: write_count SHALL be constant 0 and the counter SHALL not be built; all other behaviour is identical.

Verification
REQ-031 Reset, DEPTH=16 -> init_done rises exactly 16 cycles after reset deasserts; then a read of every slot 0..15 returns 0.
REQ-032 Write slot 3 = 0xA5 pattern, rd_req slot 3 next cycle -> read_valid 1 cycle later with the 0xA5 pattern; slot 4 still reads 0.
REQ-033 Same-cycle write slot 7 = X and rd_req slot 7 -> read_state = X one cycle later.
REQ-034 Write to address 16 and read of address 20 -> addr_error=1, read_state=0 with read_valid=1, all slots unchanged.
REQ-035 rd_req in cycle 5 of clear -> no read_valid, drop_error=1; reset at cycle 8 of clear -> init_done rises 16 cycles after release.
REQ-036 With macro defined, 3 in-range writes plus 1 out-of-range write -> write_count=3; with macro undefined -> write_count=0.
